// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings presented on op_i
//   - FSM state encoding
//   - 5-bit datapath CONTROL code per op:
//       [4] divide path, [3] multiply path, [2] signed operands,
//       [1] write HI in FIX, [0] write LO in FIX
package muldiv_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_e;

    localparam int unsigned CTRL_DIV    = 4;
    localparam int unsigned CTRL_MUL    = 3;
    localparam int unsigned CTRL_SIGNED = 2;
    localparam int unsigned CTRL_WR_HI  = 1;
    localparam int unsigned CTRL_WR_LO  = 0;

    localparam logic [4:0] CTRL_CODE_MUL  = 5'b01111;
    localparam logic [4:0] CTRL_CODE_MULU = 5'b01011;
    localparam logic [4:0] CTRL_CODE_DIV  = 5'b10111;
    localparam logic [4:0] CTRL_CODE_DIVU = 5'b10011;

    function automatic logic [4:0] op_ctrl(input logic [1:0] op);
        logic [4:0] ctrl;
        unique case (op)
            OP_MUL:  ctrl = CTRL_CODE_MUL;
            OP_MULU: ctrl = CTRL_CODE_MULU;
            OP_DIV:  ctrl = CTRL_CODE_DIV;
            default: ctrl = CTRL_CODE_DIVU;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i    : multiply -> {partial upper, remaining multiplier bits}
//              divide   -> {partial remainder, remaining dividend / quotient bits}
//   m_i      : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_o    : accumulator after this iteration
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   m_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier LSB is set, then shift right.
        mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, m_i} : '0);

        // Divide: shift the next dividend bit into the remainder and trial-subtract.
        // The remainder stays below the divisor, so WIDTH bits hold it after each step.
        div_shift = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        q_bit     = (div_shift >= {1'b0, m_i});
        div_diff  = div_shift[WIDTH-1:0] - m_i;
        rem_next  = q_bit ? div_diff : div_shift[WIDTH-1:0];

        if (is_div_i) begin
            acc_o = {rem_next, acc_i[WIDTH-2:0], q_bit};
        end else begin
            acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_mul_div.sv
// Iterative multiply/divide unit for the HI/LO path, one bit per clock.
//   clk_i, rst_ni   : clock (rising edge), asynchronous active-low clear
//   start_i         : request, sampled only while idle, with op_i / a_i / b_i
//   op_i            : 00 MUL, 01 MULU, 10 DIV, 11 DIVU
//   busy_o          : high from the cycle after acceptance through the done cycle
//   done_o          : one-cycle pulse, hi_o/lo_o valid from then on
//   hi_o, lo_o      : product upper/lower half, or remainder/quotient
//   div_by_zero_o   : set with done for a divide by zero, cleared on next accepted start
module seq_mul_div
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         ctrl_q, ctrl_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               sb_q, sb_d;
    logic               bz_q, bz_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [2*WIDTH-1:0] step_acc;
    logic [4:0]         ctrl_in;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               res_neg, rem_neg;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   hi_n, lo_n;

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div_i(ctrl_q[CTRL_DIV]),
        .acc_i   (acc_q),
        .m_i     (m_q),
        .acc_o   (step_acc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            a_raw_q <= '0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            m_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            a_raw_q <= a_raw_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        a_raw_d = a_raw_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        m_d     = m_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        ctrl_in = op_ctrl(op_i);
        a_neg   = ctrl_in[CTRL_SIGNED] & a_i[WIDTH-1];
        b_neg   = ctrl_in[CTRL_SIGNED] & b_i[WIDTH-1];
        a_mag   = a_neg ? -a_i : a_i;
        b_mag   = b_neg ? -b_i : b_i;

        // The raw dividend sign lives in a_raw_q; signedness gates both corrections.
        res_neg = ctrl_q[CTRL_SIGNED] & (a_raw_q[WIDTH-1] ^ sb_q);
        rem_neg = ctrl_q[CTRL_SIGNED] & a_raw_q[WIDTH-1];
        mul_res = res_neg ? -acc_q : acc_q;
        quo     = res_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem     = rem_neg ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        hi_n    = hi_q;
        lo_n    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    cnt_d   = CNT_W'(WIDTH);
                    ctrl_d  = ctrl_in;
                    a_raw_d = a_i;
                    sb_d    = b_i[WIDTH-1];
                    bz_d    = (b_i == '0);
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    if (ctrl_in[CTRL_DIV]) begin
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                        m_d   = b_mag;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                        m_d   = a_mag;
                    end
                end
            end
            RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                done_d  = 1'b1;
                if (ctrl_q[CTRL_DIV]) begin
                    dbz_d = bz_q;
                    hi_n  = bz_q ? a_raw_q : rem;
                    lo_n  = bz_q ? '1 : quo;
                end else if (ctrl_q[CTRL_MUL]) begin
                    hi_n = mul_res[2*WIDTH-1:WIDTH];
                    lo_n = mul_res[WIDTH-1:0];
                end
                if (ctrl_q[CTRL_WR_HI]) begin
                    hi_d = hi_n;
                end
                if (ctrl_q[CTRL_WR_LO]) begin
                    lo_d = lo_n;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Self-checking bench for seq_mul_div: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_seq_mul_div;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;

    int n_tests;
    int n_fail;
    logic [W-1:0] prev_hi;
    logic [W-1:0] prev_lo;

    seq_mul_div #(
        .WIDTH(W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .op_i         (op),
        .a_i          (a),
        .b_i          (b),
        .busy_o       (busy),
        .done_o       (done),
        .hi_o         (hi),
        .lo_o         (lo),
        .div_by_zero_o(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: exact 64-bit product, truncating signed division.
    task automatic model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output logic [W-1:0] mhi, output logic [W-1:0] mlo,
                         output logic mdbz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa   = longint'($signed(ma));
        sb   = longint'($signed(mb));
        mdbz = 1'b0;
        case (mop)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'd0, ma} * {32'd0, mb};
            2'b10: begin
                if (mb == 0) begin
                    p    = {ma, 32'hFFFF_FFFF};
                    mdbz = 1'b1;
                end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                    p = {32'd0, ma};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (mb == 0) begin
                    p    = {ma, 32'hFFFF_FFFF};
                    mdbz = 1'b1;
                end else begin
                    p = {ma % mb, ma / mb};
                end
            end
        endcase
        mhi = p[63:32];
        mlo = p[31:0];
    endtask

    // Issue one operation and check timing and results. inj_busy > 0 pulses a stray
    // start that many edges after acceptance; inj_done pulses one in the done cycle.
    task automatic run_op(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                          input int inj_busy, input bit inj_done);
        logic [W-1:0] e_hi, e_lo;
        logic         e_dbz;
        int           k;
        bit           seen;
        bit           bad;
        model(mop, ma, mb, e_hi, e_lo, e_dbz);
        @(negedge clk);
        start = 1'b1;
        op    = mop;
        a     = ma;
        b     = mb;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_after_accept", 64'(busy), 64'd1);
        check_eq("dbz_clear_on_start", 64'(dbz), 64'd0);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < int'(W) + 8) begin
            if (inj_busy > 0 && k == inj_busy) begin
                start = 1'b1;
                op    = 2'b00;
                a     = 32'd2;
                b     = 32'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
            if (k == int'(W)) begin
                check_eq("hold_before_fix", {hi, lo}, {prev_hi, prev_lo});
            end
            seen = done;
        end
        check_eq("latency", 64'(k), 64'(W + 1));
        check_eq("result", {hi, lo}, {e_hi, e_lo});
        check_eq("dbz", 64'(dbz), 64'(e_dbz));
        check_eq("busy_with_done", 64'(busy), 64'd1);
        if (inj_done) begin
            start = 1'b1;
            op    = 2'b00;
            a     = 32'd2;
            b     = 32'd3;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("idle_after_done", {62'd0, busy, done}, 64'd0);
        if (inj_done || inj_busy > 0) begin
            bad = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                if (busy || done) bad = 1'b1;
            end
            check_eq("no_extra_done", 64'(bad), 64'd0);
            check_eq("result_kept", {hi, lo}, {e_hi, e_lo});
        end
        prev_hi = e_hi;
        prev_lo = e_lo;
    endtask

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a, r_b;
        int           sel;
        n_tests = 0;
        n_fail  = 0;
        prev_hi = '0;
        prev_lo = '0;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state", {29'd0, busy, done, dbz, hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 32'd16, 32'd32, 0, 1'b0);
        run_op(2'b00, -32'sd3, 32'd5, 0, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(2'b10, -32'sd7, 32'd2, 0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(2'b11, 32'd100, 32'd0, 0, 1'b0);
        run_op(2'b10, 32'd9, 32'd0, 0, 1'b0);
        run_op(2'b01, 32'd7, 32'd6, 0, 1'b0);
        run_op(2'b00, 32'd16, 32'd32, 5, 1'b1);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);

        // Clear in the middle of RUN discards everything at once.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd16;
        b     = 32'd32;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("clear_mid_run", {29'd0, busy, done, dbz, hi, lo}, 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        prev_hi = '0;
        prev_lo = '0;
        run_op(2'b00, 32'd16, 32'd32, 0, 1'b0);

        for (int t = 0; t < 150; t++) begin
            r_op = 2'($urandom_range(0, 3));
            sel  = int'($urandom_range(0, 9));
            case (sel)
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 15));
                2:       r_b = 32'hFFFF_FFFF;
                3:       r_b = 32'd1;
                default: r_b = $urandom;
            endcase
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       r_a = 32'h8000_0000;
                1:       r_a = 32'($urandom_range(0, 255));
                default: r_a = $urandom;
            endcase
            run_op(r_op, r_a, r_b, (t % 16 == 3) ? int'($urandom_range(1, 30)) : 0, t % 16 == 7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mul_div.md
# seq_mul_div

Iterative, parametrised multiply/divide unit for the datapath's HI/LO path, replacing the single-cycle multiplier. It accepts two WIDTH-bit operands and an operation code, then iterates one bit per clock. It returns a 2*WIDTH-bit product, or a quotient/remainder pair, on HI/LO with a start/done handshake. It sits between the Y register / bus and the Z/HI/LO registers. The control sequencer holds its step until `done` rises.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH; minimum 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

- Clock  in  1  system clock, rising edge.
- Clear  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; sampled only when busy=0.
- op  in  2  00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU; sampled with start.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; hi/lo valid from this cycle on.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.
- div_by_zero  out  1  set with done for DIV/DIVU with b=0; cleared on next accepted start.

## Operation
- Reset (Clear=0, any time, including mid-operation): state IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0. The in-flight operation is discarded.
- States:
  - IDLE: on start=1, latch op, |a|, |b| and the sign bits. Signed ops take magnitudes; unsigned ops take raw values. Go to RUN with counter=WIDTH.
  - RUN: one iteration per cycle; the counter decrements; at counter=1 go to FIX.
  - FIX: apply sign correction and write hi/lo; go to DONE.
  - DONE: done=1 for one cycle; return to IDLE.
- Multiply: shift-add over the WIDTH-bit magnitudes. In FIX, negate the 2*WIDTH result if the op is signed and the signs differ. {hi,lo} = exact product.
- Divide: restoring division, one quotient bit per RUN cycle.
  - Signed: the quotient truncates toward zero and the remainder takes the dividend's sign.
  - Signed -2^(WIDTH-1) / -1: lo = -2^(WIDTH-1) (wraps), hi = 0, no flag.
  - b=0: lo = all ones, hi = a (raw), div_by_zero=1. Latency is unchanged.
- hi/lo hold their value until FIX of the next operation. They do not change while busy before FIX.
- start while busy=1 or during DONE: ignored, with no effect on the operation in flight.
- start during the IDLE cycle immediately after DONE: accepted normally (back-to-back).

## Timing
- Start accepted at rising edge E0. busy=1 after E0. RUN occupies edges E1..E(WIDTH). FIX updates hi/lo at E(WIDTH+1). done=1 after E(WIDTH+1) and drops at E(WIDTH+2), together with busy.
- Latency: done is visible WIDTH+1 edges after acceptance (33 for WIDTH=32). Throughput is one operation per WIDTH+3 cycles.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings: OP_MUL, OP_MULU, OP_DIV, OP_DIVU;
  - state enum: IDLE, RUN, FIX, DONE;
  - the 5-bit datapath CONTROL code that maps to each op.
- Sub-module `muldiv_step`: combinational single iteration, parametrised by WIDTH. For a multiply step it does a conditional add plus shift; for a divide step it does a trial subtract plus shift and produces the quotient bit.
- The top level holds the FSM, counter, operand/accumulator registers and sign fix-up.

## Test plan
- MUL, a=16, b=32 -> hi=0, lo=0x200; done exactly 33 edges after the accepting edge; busy low the cycle after done.
- MUL, a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV, a=0x80000000, b=-1 -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU, a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1, same latency. The next accepted start clears div_by_zero.
- start with a=2, b=3 pulsed while busy on a MUL 16*32 -> result is still 0x200, and there is no second done.
- Clear low mid-RUN -> busy, done, hi, lo, div_by_zero all 0 immediately. A fresh start after release completes correctly.
